// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle. mem_req is held high until the cycle in which mem_ready is also high;
// that cycle completes the access. MemWrite stays high for the whole request.
interface multicycle_control_unit_if #(
   parameter int ULA_CTRL_W = 3
);
   logic [6:0]            OP;
   logic [2:0]            Funct3;
   logic [6:0]            Funct7;
   logic                  Zero;
   logic                  Lt;
   logic                  mem_ready;
   logic                  mem_req;
   logic                  AdrSrc;
   logic                  IRWrite;
   logic                  PCWrite;
   logic                  MemWrite;
   logic                  RegWrite;
   logic [1:0]            ImmSrc;
   logic [1:0]            ULASrcA;
   logic [1:0]            ULASrcB;
   logic [ULA_CTRL_W-1:0] ULAControl;
   logic [1:0]            ResultSrc;
   logic                  illegal;
   logic [3:0]            state;

   modport master (
      input  OP, Funct3, Funct7, Zero, Lt, mem_ready,
      output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
             ImmSrc, ULASrcA, ULASrcB, ULAControl, ResultSrc, illegal, state
   );

   modport slave (
      output OP, Funct3, Funct7, Zero, Lt, mem_ready,
      input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
             ImmSrc, ULASrcA, ULASrcB, ULAControl, ResultSrc, illegal, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the 8-bit RISC-V multi-cycle datapath: fetch/decode/execute/memory/writeback
// over one ULA and one shared memory port, with a sticky illegal-instruction flag.
module multicycle_control_unit #(
   parameter int MEM_HANDSHAKE   = 1,
   parameter int TRAP_ON_ILLEGAL = 1,
   parameter int ULA_CTRL_W      = 3
) (
   input logic clk,
   input logic reset,
   multicycle_control_unit_if.master bus
);
   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                          MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                          ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
                          ILLEGAL = 4'd12;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                          OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

   logic [3:0] curState, nextState;
   logic       illegalQ;
   logic       memOk;
   logic       isR, isI, isLw, isSw, isBranch, isJal, isJalr, branchTaken;
   logic [2:0] rCtl, iCtl, ulaCtl;

   assign memOk = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

   // Only the 22 supported encodings decode; every other bit pattern is illegal.
   always_comb begin
      isR = 1'b0; isI = 1'b0; isLw = 1'b0; isSw = 1'b0;
      isBranch = 1'b0; isJal = 1'b0; isJalr = 1'b0;
      rCtl = 3'b000; iCtl = 3'b000; branchTaken = 1'b0;
      case (bus.OP)
         OP_R: begin
            if (bus.Funct7 == 7'b0000000) begin
               isR = 1'b1;
               case (bus.Funct3)
                  3'b000:  rCtl = 3'b000;
                  3'b111:  rCtl = 3'b010;
                  3'b110:  rCtl = 3'b011;
                  3'b100:  rCtl = 3'b100;
                  3'b010:  rCtl = 3'b101;
                  3'b001:  rCtl = 3'b110;
                  3'b101:  rCtl = 3'b111;
                  default: isR = 1'b0;
               endcase
            end else if (bus.Funct7 == 7'b0100000 && bus.Funct3 == 3'b000) begin
               isR  = 1'b1;
               rCtl = 3'b001;
            end
         end
         OP_I: begin
            isI = 1'b1;
            case (bus.Funct3)
               3'b000:  iCtl = 3'b000;
               3'b110:  iCtl = 3'b011;
               3'b100:  iCtl = 3'b100;
               3'b010:  iCtl = 3'b101;
               3'b001:  begin iCtl = 3'b110; isI = (bus.Funct7 == 7'b0000000); end
               3'b101:  begin iCtl = 3'b111; isI = (bus.Funct7 == 7'b0000000); end
               default: isI = 1'b0;
            endcase
         end
         OP_LOAD:   isLw = (bus.Funct3 == 3'b010);
         OP_STORE:  isSw = (bus.Funct3 == 3'b010);
         OP_BRANCH: begin
            case (bus.Funct3)
               3'b000:  begin isBranch = 1'b1; branchTaken = bus.Zero;  end
               3'b001:  begin isBranch = 1'b1; branchTaken = ~bus.Zero; end
               3'b100:  begin isBranch = 1'b1; branchTaken = bus.Lt;    end
               3'b101:  begin isBranch = 1'b1; branchTaken = ~bus.Lt;   end
               default: isBranch = 1'b0;
            endcase
         end
         OP_JAL:    isJal  = 1'b1;
         OP_JALR:   isJalr = (bus.Funct3 == 3'b000);
         default:   ;
      endcase
   end

   always_comb begin
      nextState = FETCH;
      case (curState)
         FETCH:    nextState = memOk ? DECODE : FETCH;
         DECODE: begin
            if (isLw || isSw)  nextState = MEMADR;
            else if (isR)      nextState = EXECR;
            else if (isI)      nextState = EXECI;
            else if (isBranch) nextState = BRANCH;
            else if (isJal)    nextState = JAL;
            else if (isJalr)   nextState = JALR;
            else               nextState = ILLEGAL;
         end
         MEMADR:   nextState = isSw ? MEMWRITE : MEMREAD;
         MEMREAD:  nextState = memOk ? MEMWB : MEMREAD;
         MEMWB:    nextState = FETCH;
         MEMWRITE: nextState = memOk ? FETCH : MEMWRITE;
         EXECR:    nextState = ALUWB;
         EXECI:    nextState = ALUWB;
         ALUWB:    nextState = FETCH;
         BRANCH:   nextState = FETCH;
         JALR:     nextState = JAL;
         JAL:      nextState = ALUWB;
         ILLEGAL:  nextState = (TRAP_ON_ILLEGAL != 0) ? ILLEGAL : FETCH;
         default:  nextState = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curState <= FETCH;
         illegalQ <= 1'b0;
      end else begin
         curState <= nextState;
         if (nextState == ILLEGAL) illegalQ <= 1'b1;
      end
   end

   // Outputs follow the state; IRWrite/PCWrite in FETCH and PCWrite in BRANCH also follow the inputs.
   always_comb begin
      bus.mem_req = 1'b0; bus.AdrSrc = 1'b0; bus.IRWrite = 1'b0; bus.PCWrite = 1'b0;
      bus.MemWrite = 1'b0; bus.RegWrite = 1'b0; bus.ImmSrc = 2'b00; bus.ULASrcA = 2'b00;
      bus.ULASrcB = 2'b00; bus.ResultSrc = 2'b00; ulaCtl = 3'b000;
      case (curState)
         FETCH: begin
            bus.mem_req = 1'b1; bus.ULASrcB = 2'b10; bus.ResultSrc = 2'b10;
            bus.IRWrite = memOk; bus.PCWrite = memOk;
         end
         DECODE: begin
            bus.ULASrcA = 2'b01; bus.ULASrcB = 2'b01;
            bus.ImmSrc  = isJal ? 2'b11 : 2'b10;
         end
         MEMADR: begin
            bus.ULASrcA = 2'b10; bus.ULASrcB = 2'b01;
            bus.ImmSrc  = isSw ? 2'b01 : 2'b00;
         end
         MEMREAD:  begin bus.mem_req = 1'b1; bus.AdrSrc = 1'b1; end
         MEMWB:    begin bus.ResultSrc = 2'b01; bus.RegWrite = 1'b1; end
         MEMWRITE: begin bus.mem_req = 1'b1; bus.MemWrite = 1'b1; bus.AdrSrc = 1'b1; end
         EXECR:    begin bus.ULASrcA = 2'b10; ulaCtl = rCtl; end
         EXECI:    begin bus.ULASrcA = 2'b10; bus.ULASrcB = 2'b01; ulaCtl = iCtl; end
         ALUWB:    bus.RegWrite = 1'b1;
         BRANCH: begin
            bus.ULASrcA = 2'b10; ulaCtl = 3'b001;
            bus.PCWrite = isBranch & branchTaken;
         end
         JALR:     begin bus.ULASrcA = 2'b10; bus.ULASrcB = 2'b01; end
         JAL:      begin bus.ULASrcA = 2'b01; bus.ULASrcB = 2'b10; bus.PCWrite = 1'b1; end
         default:  ;
      endcase
      if (reset) begin
         bus.mem_req = 1'b0; bus.AdrSrc = 1'b0; bus.IRWrite = 1'b0; bus.PCWrite = 1'b0;
         bus.MemWrite = 1'b0; bus.RegWrite = 1'b0; bus.ImmSrc = 2'b00; bus.ULASrcA = 2'b00;
         bus.ULASrcB = 2'b00; bus.ResultSrc = 2'b00; ulaCtl = 3'b000;
      end
   end

   assign bus.ULAControl = ULA_CTRL_W'(ulaCtl);
   assign bus.illegal    = illegalQ;
   assign bus.state      = curState;
endmodule
